instruction_queue_register: RTL
===============================

# instruction_queue_register

Parametrised instruction register with a prefetch queue, placed between program memory and the controller. It accepts instructions from memory through a valid/ready handshake into a DEPTH-entry FIFO. On each controller load it splits the head instruction into opcode and operand registers. When the controller loads while the queue is empty, it inserts a NOP bubble. It can optionally assemble two-word extended-operand instructions.

## Interface
- INSTR_W, 8: instruction word width
- OPCODE_W, 4: opcode field width, taken from the top bits; DATA_W = INSTR_W − OPCODE_W
- DEPTH, 4: queue entries; must be a power of two and ≥ 2
- EXT_OPCODE, 4'hF: opcode value that marks an extended-operand instruction
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_in  in  INSTR_W  instruction word from memory
- instr_valid  in  1  instr_in is valid
- instr_ready  out  1  queue can accept a word; equals (count < DEPTH), derived from registered count
- load_ir  in  1  controller request to load the next instruction
- flush  in  1  synchronous queue and IR clear (branch or jump)
- opcode  out  OPCODE_W  registered opcode
- data_out  out  DATA_W  registered operand, instruction[DATA_W-1:0]
- ext_data  out  INSTR_W  registered extended operand (second word)
- ir_valid  out  1  opcode/data_out hold a real instruction, not a bubble
- count  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- **Push:**
  - Occurs when instr_valid && instr_ready.
  - instr_in is written at the write pointer; the pointer wraps modulo DEPTH.
- **Load, queue holds a complete instruction:**
  - On load_ir, the IR takes opcode ← head[INSTR_W-1:DATA_W] and data_out ← head[DATA_W-1:0].
  - ir_valid ← 1 and the head is popped.
- **Load, no complete instruction available:**
  - On load_ir, opcode ← 0 and data_out ← 0 (NOP); ext_data ← 0; ir_valid ← 0.
  - Nothing is popped.
- **No load:** all IR outputs hold.
- **Push and load in the same cycle:**
  - Both take effect.
  - count changes by +1 − (words popped).
- **Full:**
  - instr_ready = 0, including in a cycle where a pop occurs. There is no same-cycle pass-through.
- **Empty:** loads produce bubbles only; count never underflows.
- **Flush:**
  - Clears both pointers and count, sets the IR to NOP, clears ext_data and sets ir_valid = 0.
  - Flush overrides push and load_ir in the same cycle; the pushed word is dropped.
- **Reset (asserted at any time, including mid-queue):**
  - opcode = 0, data_out = 0, ext_data = 0, ir_valid = 0, count = 0, both pointers = 0.
  - instr_ready = 1 once reset is released.

## Timing
- All outputs are registered; they update on the rising edge where load_ir is sampled high.
- A word pushed at edge N is loadable at edge N+1. The minimum latency from memory to IR is 2 edges.
- Throughput: one single-word instruction per cycle, sustained.
- count and instr_ready reflect state after the most recent edge.

## Configuration
- **IR_EXT_OPERAND_EN defined:**
  - A head whose opcode equals EXT_OPCODE is complete only when count ≥ 2.
  - On load it pops both words: opcode and data_out come from the first word, and ext_data ← the second word.
  - With count = 1 and an EXT head, a load gives a NOP bubble and no pop.
  - Push and an extended pop in the same cycle give count += 1 − 2.
  - Loads of non-EXT instructions set ext_data ← 0.
- **IR_EXT_OPERAND_EN undefined:**
  - EXT_OPCODE is an ordinary opcode and every load pops one word.
  - ext_data is tied to 0.

## Structure
- Shared package ir_pkg holds:
  - OPCODE_NOP (4'h0) and the default EXT_OPCODE;
  - a localparam helper for DATA_W;
  - the count width function.
- Sub-module ir_fifo: a circular buffer with read/write pointers and count, and peek access to head and head+1.
- The top level holds the IR registers, completeness logic and bubble insertion.

## Test plan
- **Reset then load, queue empty:**
  - Assert reset mid-run, release, then pulse load_ir.
  - Required: opcode = 0, data_out = 0, ir_valid = 0, count = 0, instr_ready = 1.
- **Single push and load:**
  - Push 8'h3A, then load_ir on the next edge.
  - Required: opcode = 4'h3, data_out = 4'hA, ir_valid = 1, count = 0.
- **Fill to full (DEPTH = 4):**
  - Push 0x11, 0x22, 0x33, 0x44, then hold instr_valid high with 0x55.
  - Required: instr_ready = 0 and count = 4; 0x55 is not accepted until the cycle after the first pop.
- **Simultaneous push and load at count = 2:**
  - Required: count stays 2; loads return words in FIFO order across pointer wrap.
- **Flush with push and load pending:**
  - Required: count = 0, IR is NOP, ir_valid = 0, and the pushed word is absent.
- **Extended operand (IR_EXT_OPERAND_EN):**
  - Push 0xF7, then load before the second word arrives. Required: NOP bubble, count = 1.
  - Push 0xC4, then load. Required: opcode = F, data_out = 7, ext_data = 0xC4, count = 0.

Source files
------------

// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared constants and sizing helpers for the instruction queue register.
//   OPCODE_NOP      : opcode loaded into the IR for a bubble
//   EXT_OPCODE_DEF  : default opcode marking an extended-operand instruction
//   data_width()    : operand field width (INSTR_W - OPCODE_W)
//   count_width()   : occupancy counter width, able to hold 0..DEPTH
// ---------------------------------------------------------------------------
package ir_pkg;

  localparam logic [3:0] OPCODE_NOP     = 4'h0;
  localparam logic [3:0] EXT_OPCODE_DEF = 4'hF;

  function automatic int data_width(input int instr_w, input int opcode_w);
    return instr_w - opcode_w;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ir_fifo.sv
// ---------------------------------------------------------------------------
// ir_fifo
// Circular prefetch buffer with read/write pointers and an occupancy count.
// Exposes the head word and, when IR_EXT_OPERAND_EN is defined, the word
// behind it so the consumer can take a two-word instruction in one pop.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   flush        : synchronous clear of pointers and count
//   push         : write data_in at the write pointer (caller qualifies it)
//   data_in      : word to write
//   pop_n        : number of words to pop this cycle (0, 1 or 2)
//   head         : word at the read pointer
//   head_next    : word at read pointer + 1 (IR_EXT_OPERAND_EN only)
//   count        : current occupancy
//   ready        : count < DEPTH, from the registered count
// ---------------------------------------------------------------------------
module ir_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  data_in,
  input  logic [1:0]    pop_n,
  output logic [W-1:0]  head,
`ifdef IR_EXT_OPERAND_EN
  output logic [W-1:0]  head_next,
`endif
  output logic [CW-1:0] count,
  output logic          ready
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push) - CW'(pop_n);
    end
  end

  assign head      = mem[rd_ptr];
`ifdef IR_EXT_OPERAND_EN
  assign head_next = mem[rd_ptr + AW'(1)];
`endif
  assign ready     = (count < CW'(DEPTH));

endmodule

// File: rtl/instruction_queue_register.sv
// ---------------------------------------------------------------------------
// instruction_queue_register
// Instruction register fed by a DEPTH-entry prefetch queue. Memory pushes
// words via instr_valid/instr_ready; each load_ir splits the head word into
// opcode/data_out, or inserts a NOP bubble when no complete instruction is
// queued. Optional feature macro IR_EXT_OPERAND_EN: an EXT_OPCODE head needs
// two queued words and loads its second word into ext_data.
//
// Handshake: a word transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_ready depends only on the registered count
// (never on this cycle's pop), and flush in the same cycle drops the word.
//
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   instr_in      : instruction word from memory
//   instr_valid   : instr_in valid
//   instr_ready   : queue can accept a word (count < DEPTH)
//   load_ir       : controller request to load the next instruction
//   flush         : synchronous clear of queue and IR
//   opcode        : registered opcode field
//   data_out      : registered operand field
//   ext_data      : registered extended operand (0 unless feature enabled)
//   ir_valid      : IR holds a real instruction, not a bubble
//   count         : queue occupancy
// ---------------------------------------------------------------------------
module instruction_queue_register
  import ir_pkg::*;
#(
  parameter int                    INSTR_W    = 8,
  parameter int                    OPCODE_W   = 4,
  parameter int                    DEPTH      = 4,
  parameter logic [OPCODE_W-1:0]   EXT_OPCODE = EXT_OPCODE_DEF,
  localparam int                   DATA_W     = data_width(INSTR_W, OPCODE_W),
  localparam int                   CW         = count_width(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instr_in,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                load_ir,
  input  logic                flush,
  output logic [OPCODE_W-1:0] opcode,
  output logic [DATA_W-1:0]   data_out,
  output logic [INSTR_W-1:0]  ext_data,
  output logic                ir_valid,
  output logic [CW-1:0]       count
);

  logic [INSTR_W-1:0] head;
  logic               push;
  logic               complete;
  logic [1:0]         pop_n;
  logic [OPCODE_W-1:0] head_op;

  assign push    = instr_valid && instr_ready && !flush;
  assign head_op = head[INSTR_W-1:DATA_W];

`ifdef IR_EXT_OPERAND_EN
  logic [INSTR_W-1:0] head_next;
  logic               is_ext;

  // An extended instruction is only loadable once its operand word is queued.
  assign is_ext   = (head_op == EXT_OPCODE);
  assign complete = is_ext ? (count >= CW'(2)) : (count != '0);
  assign pop_n    = (load_ir && !flush && complete) ? (is_ext ? 2'd2 : 2'd1) : 2'd0;
`else
  assign complete = (count != '0);
  assign pop_n    = (load_ir && !flush && complete) ? 2'd1 : 2'd0;
`endif

  ir_fifo #(
    .W     (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .data_in   (instr_in),
    .pop_n     (pop_n),
    .head      (head),
`ifdef IR_EXT_OPERAND_EN
    .head_next (head_next),
`endif
    .count     (count),
    .ready     (instr_ready)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode   <= OPCODE_W'(OPCODE_NOP);
      data_out <= '0;
      ir_valid <= 1'b0;
    end else if (flush) begin
      opcode   <= OPCODE_W'(OPCODE_NOP);
      data_out <= '0;
      ir_valid <= 1'b0;
    end else if (load_ir) begin
      if (complete) begin
        opcode   <= head_op;
        data_out <= head[DATA_W-1:0];
        ir_valid <= 1'b1;
      end else begin
        opcode   <= OPCODE_W'(OPCODE_NOP);
        data_out <= '0;
        ir_valid <= 1'b0;
      end
    end
  end

`ifdef IR_EXT_OPERAND_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_data <= '0;
    end else if (flush) begin
      ext_data <= '0;
    end else if (load_ir) begin
      ext_data <= (complete && is_ext) ? head_next : '0;
    end
  end
`else
  assign ext_data = '0;
`endif

endmodule
